pdata: RTL and testbench

- Bit-serial multiply-accumulate datapath for one network node.
- Sits directly downstream of the packet controller. It consumes the controller's registered 3-bit opcode and the shared serial line rx.
- Loads operands serially, performs MUL / MUL_ADD on single-cycle opcode pulses, and shifts the result out on tx.
- In OUT_RES_ADD mode, tx carries the bit-serial sum of the incoming stream and the local result, for daisy-chained accumulation.

---
 rtl/pdata.sv | 121 ++++++++++++
 tb/tb_pdata.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pdata.sv
// pdata: bit-serial multiply-accumulate datapath for one network node.
//
// Operands and the result move over the shared serial line rx, LSB first.
// The controller's registered opcode selects one action per cycle. Multiply
// and accumulate take a single cycle. The result is shifted out on tx, and
// in OUT_RES_ADD mode tx carries the running serial sum rx + res. That sum
// feeds the next node in a daisy chain.
//
// Ports:
//   clk     system clock
//   Rst     synchronous active-high reset
//   opcode  3-bit command from the packet controller
//   rx      shared serial input line, LSB first
//   tx      serial result line, LSB first, idles high (registered)
//   ovf     sticky signed-overflow flag for MUL_ADD accumulation
module pdata #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 32
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic [2:0] opcode,
    input  logic       rx,
    output logic       tx,
    output logic       ovf
);

    typedef enum logic [2:0] {
        OUT_DATA1   = 3'd0,
        OUT_DATA2   = 3'd1,
        OUT_RES     = 3'd2,
        OUT_RES_ADD = 3'd3,
        LOAD_RES    = 3'd4,
        MUL         = 3'd5,
        MUL_ADD     = 3'd6,
        NO_OP       = 3'd7
    } op_t;

    localparam int CW = $clog2(RES_W) + 1;
    localparam logic [CW-1:0] RES_CNT = CW'(RES_W);

    op_t                op, op_q;
    logic [DATA_W-1:0]  data1, data2;
    logic [RES_W-1:0]   res;
    logic [CW-1:0]      bcnt;
    logic               carry;

    assign op = op_t'(opcode);

    // Product and accumulate path
    logic signed [2*DATA_W-1:0] prod;
    logic [RES_W-1:0]           prod_ext, acc;
    logic                       add_ovf;

    assign prod     = (2*DATA_W)'($signed(data1)) * (2*DATA_W)'($signed(data2));
    assign prod_ext = RES_W'(prod);
    assign acc      = res + prod_ext;
    // Overflow occurs when both addends share a sign and the sum's sign differs.
    assign add_ovf  = (res[RES_W-1] == prod_ext[RES_W-1]) &&
                      (acc[RES_W-1] != res[RES_W-1]);

    // Shift-out path. A new shift-out begins when the opcode changes into
    // OUT_RES or OUT_RES_ADD, or switches between the two. The first cycle
    // uses bit index 0 and carry-in 0 directly, so no idle cycle is needed
    // to clear the counter first.
    logic          shifting, start, in_range, rbit, cin;
    logic [CW-1:0] t_idx;
    logic [1:0]    s;

    assign shifting = (op == OUT_RES) || (op == OUT_RES_ADD);
    assign start    = shifting && (op_q != op);
    assign t_idx    = start ? '0 : bcnt;
    assign cin      = start ? 1'b0 : carry;
    assign in_range = t_idx < RES_CNT;
    assign rbit     = in_range ? res[t_idx[CW-2:0]] : 1'b0;
    assign s        = {1'b0, rbit} + {1'b0, rx} + {1'b0, cin};

    always_ff @(posedge clk) begin
        if (Rst) begin
            data1 <= '0;
            data2 <= '0;
            res   <= '0;
            tx    <= 1'b1;
            ovf   <= 1'b0;
            bcnt  <= '0;
            carry <= 1'b0;
            op_q  <= NO_OP;
        end else begin
            op_q <= op;
            tx   <= 1'b1;
            case (op)
                OUT_DATA1: data1 <= {rx, data1[DATA_W-1:1]};
                OUT_DATA2: data2 <= {rx, data2[DATA_W-1:1]};
                LOAD_RES: begin
                    res <= {rx, res[RES_W-1:1]};
                    ovf <= 1'b0;
                end
                MUL: begin
                    res <= prod_ext;
                    ovf <= 1'b0;
                end
                MUL_ADD: begin
                    res <= acc;
                    ovf <= ovf | add_ovf;
                end
                OUT_RES, OUT_RES_ADD: begin
                    if (in_range) begin
                        tx    <= (op == OUT_RES_ADD) ? s[0] : rbit;
                        carry <= (op == OUT_RES_ADD) ? s[1] : 1'b0;
                        bcnt  <= t_idx + CW'(1);
                    end else begin
                        // Past the last bit: stay saturated, tx idles high.
                        bcnt  <= t_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pdata.sv
module tb_pdata;

    localparam logic [2:0] OUT_DATA1 = 3'd0, OUT_DATA2 = 3'd1, OUT_RES = 3'd2,
                           OUT_RES_ADD = 3'd3, LOAD_RES = 3'd4, MUL = 3'd5,
                           MUL_ADD = 3'd6, NO_OP = 3'd7;

    logic       clk = 1'b0;
    logic       Rst;
    logic [2:0] opcode;
    logic       rx;
    logic       tx;
    logic       ovf;

    pdata #(.DATA_W(16), .RES_W(32)) dut (
        .clk(clk), .Rst(Rst), .opcode(opcode), .rx(rx), .tx(tx), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state, kept as plain numbers
    logic [15:0] m_d1, m_d2;
    logic [31:0] m_res;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] op, input logic b);
        @(negedge clk);
        opcode = op;
        rx     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Rst = 1'b1;
        @(posedge clk);
        #1;
        Rst   = 1'b0;
        m_d1  = '0;
        m_d2  = '0;
        m_res = '0;
        m_ovf = 1'b0;
    endtask

    task automatic idle();
        step(NO_OP, 1'b0);
        chk("idle_tx", {31'b0, tx}, 32'd1);
    endtask

    task automatic load_d(input logic which, input logic [15:0] v);
        for (int i = 0; i < 16; i++) step(which ? OUT_DATA2 : OUT_DATA1, v[i]);
        if (which) m_d2 = v; else m_d1 = v;
    endtask

    task automatic load_res(input logic [31:0] v);
        for (int i = 0; i < 32; i++) step(LOAD_RES, v[i]);
        m_res = v;
        m_ovf = 1'b0;
        chk("load_ovf", {31'b0, ovf}, {31'b0, m_ovf});
    endtask

    task automatic do_mul(input logic add);
        longint p, sm;
        p = longint'($signed(m_d1)) * longint'($signed(m_d2));
        step(add ? MUL_ADD : MUL, 1'b0);
        if (add) begin
            sm = longint'($signed(m_res)) + p;
            if (sm > 64'sd2147483647 || sm < -64'sd2147483648) m_ovf = 1'b1;
            m_res = sm[31:0];
        end else begin
            m_res = p[31:0];
            m_ovf = 1'b0;
        end
        chk(add ? "muladd_ovf" : "mul_ovf", {31'b0, ovf}, {31'b0, m_ovf});
    endtask

    // Hold a shift-out opcode for n cycles and compare the collected stream
    // against res (or res + rxword) for the bits that were shifted.
    task automatic shift_out(input string tag, input logic [2:0] op,
                             input logic [31:0] rxword, input int n);
        logic [31:0] got, exp, mask;
        got  = '0;
        exp  = (op == OUT_RES_ADD) ? m_res + rxword : m_res;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        for (int t = 0; t < n; t++) begin
            step(op, (t < 32) ? rxword[t] : 1'b0);
            if (t < 32) got[t] = tx;
            else chk({tag, "_tail"}, {31'b0, tx}, 32'd1);
        end
        chk(tag, got & mask, exp & mask);
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, m_ovf});
    endtask

    initial begin
        Rst = 1'b1; opcode = NO_OP; rx = 1'b0;
        do_reset();
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);

        // Reset state shifts out as 32 zeros, then idles high
        shift_out("rst_res", OUT_RES, 32'd0, 40);
        idle();

        // Signed multiply: 3 * -2
        load_d(0, 16'h0003);
        load_d(1, 16'hFFFE);
        do_mul(0);
        shift_out("mul_neg", OUT_RES, 32'd0, 34);
        chk("mul_neg_model", m_res, 32'hFFFF_FFFA);
        idle();

        // Accumulate
        load_d(0, 16'd3);
        load_d(1, 16'd4);
        do_mul(1);
        shift_out("acc1", OUT_RES, 32'd0, 32);
        idle();
        do_mul(1);
        shift_out("acc2", OUT_RES, 32'd0, 32);
        chk("acc2_model", m_res, 32'h0000_0012);
        idle();

        // Signed overflow is sticky until MUL or LOAD_RES
        load_res(32'h7FFF_FFFF);
        load_d(0, 16'd1);
        load_d(1, 16'd1);
        do_mul(1);
        chk("ovf_set", {31'b0, ovf}, 32'd1);
        shift_out("ovf_res", OUT_RES, 32'd0, 32);
        idle();
        do_mul(1);
        chk("ovf_sticky", {31'b0, ovf}, 32'd1);
        do_mul(0);
        chk("ovf_clr", {31'b0, ovf}, 32'd0);

        // Serial add with carry ripple
        load_res(32'h0000_000A);
        shift_out("add_a", OUT_RES_ADD, 32'h0000_0005, 33);
        idle();
        load_res(32'hFFFF_FFFF);
        shift_out("add_rip", OUT_RES_ADD, 32'h0000_0001, 33);
        idle();

        // Reset in the middle of a shift-out, with ovf set beforehand
        load_res(32'h7FFF_FFFF);
        do_mul(1);
        shift_out("pre_rst", OUT_RES, 32'd0, 10);
        do_reset();
        chk("midrst_tx", {31'b0, tx}, 32'd1);
        chk("midrst_ovf", {31'b0, ovf}, 32'd0);
        idle();
        shift_out("midrst_res", OUT_RES, 32'd0, 32);
        idle();

        // Abort at bit 10, then restart from bit 0
        load_res(32'hC3A5_5A3C);
        shift_out("abort_part", OUT_RES, 32'd0, 10);
        idle();
        shift_out("abort_rest", OUT_RES, 32'd0, 33);
        // Direct switch into OUT_RES_ADD restarts at bit 0 with zero carry
        shift_out("switch", OUT_RES_ADD, 32'h1357_9BDF, 33);
        idle();

        // Randomized traffic against the reference
        for (int it = 0; it < 40; it++) begin
            load_d(0, 16'($urandom));
            load_d(1, 16'($urandom));
            case ($urandom_range(0, 3))
                0: begin load_res($urandom); do_mul(1); end
                1: do_mul(0);
                default: do_mul(1);
            endcase
            if ($urandom_range(0, 1) == 0)
                shift_out("rnd_res", OUT_RES, 32'd0, 33);
            else
                shift_out("rnd_add", OUT_RES_ADD, $urandom, 33);
            idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
